bitty_fetch: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the bitty CPU core.
- Reads 16-bit instructions from a synchronous, variable-latency program memory.
- Presents each instruction on `d_instr` and pulses `run`, then waits for the core's `done` before fetching the next one.
- Provides a program counter, HALT detection, an executed-instruction counter and a per-instruction watchdog.

---
 rtl/bitty_fetch_if.sv | 23 ++
 rtl/bitty_fetch.sv | 136 +++++++++++++
 tb/tb_bitty_fetch.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bitty_fetch_if.sv
// Fetch-stage bus: program-memory read port plus the instruction handshake to the core.
// The fetch stage is the master; memory and core sit on the slave side.
interface bitty_fetch_if #(
   parameter int ADDR_W = 8
);
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_rdata;
   logic              mem_rvalid;
   logic [15:0]       d_instr;
   logic              run;
   logic              done;

   modport master (
      output mem_rd_en, mem_addr, d_instr, run,
      input  mem_rdata, mem_rvalid, done
   );

   modport slave (
      input  mem_rd_en, mem_addr, d_instr, run,
      output mem_rdata, mem_rvalid, done
   );
endinterface

// File: rtl/bitty_fetch.sv
// Instruction-fetch stage for the bitty core: fetch, issue, wait for done, advance pc.
// Stops on the HALT word or when the per-transaction watchdog expires.
module bitty_fetch #(
   parameter int          ADDR_W     = 8,
   parameter int          START_ADDR = 0,
   parameter logic [15:0] HALT_INSTR = 16'hFFFF,
   parameter int          TIMEOUT    = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   bitty_fetch_if.master     bus,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              halted,
   output logic              error,
   output logic [15:0]       instr_count
);

   localparam int WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_MEM,
      ISSUE,
      WAIT_EXEC,
      HALT
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [15:0]       d_instr_q, d_instr_d;
   logic [15:0]       count_q, count_d;
   logic              error_q, error_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic              run_q, run_d;
   logic              rd_en_q, rd_en_d;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      d_instr_d = d_instr_q;
      count_d   = count_q;
      error_d   = error_q;
      wd_d      = wd_q;

      case (state_q)
         IDLE, HALT: begin
            if (start) begin
               pc_d    = ADDR_W'(START_ADDR);
               count_d = '0;
               error_d = 1'b0;
               state_d = REQ;
            end
         end
         REQ: begin
            wd_d    = '0;
            state_d = WAIT_MEM;
         end
         WAIT_MEM: begin
            // A valid response wins over a watchdog expiring in the same cycle.
            if (bus.mem_rvalid) begin
               if (bus.mem_rdata == HALT_INSTR) begin
                  state_d = HALT;
               end else begin
                  d_instr_d = bus.mem_rdata;
                  state_d   = ISSUE;
               end
            end else if (wd_q == WD_W'(TIMEOUT)) begin
               error_d = 1'b1;
               state_d = HALT;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         ISSUE: begin
            wd_d    = '0;
            state_d = WAIT_EXEC;
         end
         WAIT_EXEC: begin
            if (bus.done) begin
               pc_d = pc_q + 1'b1;
               if (count_q != 16'hFFFF) begin
                  count_d = count_q + 16'd1;
               end
               state_d = REQ;
            end else if (wd_q == WD_W'(TIMEOUT)) begin
               error_d = 1'b1;
               state_d = HALT;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Strobes are registered from the next state so they line up with REQ/ISSUE.
      run_d   = (state_d == ISSUE);
      rd_en_d = (state_d == REQ);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         pc_q      <= ADDR_W'(START_ADDR);
         d_instr_q <= '0;
         count_q   <= '0;
         error_q   <= 1'b0;
         wd_q      <= '0;
         run_q     <= 1'b0;
         rd_en_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         d_instr_q <= d_instr_d;
         count_q   <= count_d;
         error_q   <= error_d;
         wd_q      <= wd_d;
         run_q     <= run_d;
         rd_en_q   <= rd_en_d;
      end
   end

   assign bus.mem_rd_en = rd_en_q;
   assign bus.mem_addr  = pc_q;
   assign bus.d_instr   = d_instr_q;
   assign bus.run       = run_q;

   assign pc          = pc_q;
   assign busy        = (state_q != IDLE) && (state_q != HALT);
   assign halted      = (state_q == HALT);
   assign error       = error_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_bitty_fetch.sv
// Self-checking bench for bitty_fetch: a memory/core responder with random latencies and
// a program-walking reference model that predicts issued words, fetch addresses and final status.
module tb_bitty_fetch;

   localparam int ADDR_W = 3;
   localparam int DEPTH  = 8;
   localparam int START  = 6;
   localparam int TO     = 10;
   localparam logic [15:0] HALTW = 16'hFFFF;

   logic              clk = 1'b0;
   logic              reset;
   logic              start_req;
   logic              stray_start;
   logic              start;
   logic [ADDR_W-1:0] pc;
   logic              busy;
   logic              halted;
   logic              error;
   logic [15:0]       instr_count;

   assign start = start_req | stray_start;

   bitty_fetch_if #(.ADDR_W(ADDR_W)) bus ();

   bitty_fetch #(
      .ADDR_W    (ADDR_W),
      .START_ADDR(START),
      .HALT_INSTR(HALTW),
      .TIMEOUT   (TO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .bus        (bus),
      .pc         (pc),
      .busy       (busy),
      .halted     (halted),
      .error      (error),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [15:0]       mem [DEPTH];
   int                mem_cnt, exe_cnt;
   logic [ADDR_W-1:0] pend_addr;
   int                fault_kind, fault_idx, fetch_idx, exec_idx;
   int                lat_max, mem_fix, done_fix;
   bit                stray_en, stray_pend;

   logic [15:0] issued[$];
   int          fetched[$];
   int          viol;

   logic [15:0] exp_issued[$];
   int          exp_fetch[$];
   int          exp_pc, exp_cnt, exp_err;
   logic [15:0] exp_d;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Memory and core responder: answers strobes after a latency, optionally injects stray handshakes.
   always @(negedge clk) begin
      bus.mem_rvalid = 1'b0;
      bus.done       = 1'b0;
      bus.mem_rdata  = 16'($urandom);
      stray_start    = 1'b0;
      if (reset) begin
         mem_cnt    = 0;
         exe_cnt    = 0;
         stray_pend = 1'b0;
      end else begin
         if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
               bus.mem_rvalid = 1'b1;
               bus.mem_rdata  = mem[pend_addr];
            end
         end
         if (exe_cnt > 0) begin
            exe_cnt--;
            if (exe_cnt == 0) bus.done = 1'b1;
         end
         if (stray_pend) begin
            bus.mem_rvalid = 1'b1;
            stray_start    = 1'b1;
            stray_pend     = 1'b0;
         end
         if (bus.mem_rd_en) begin
            pend_addr = bus.mem_addr;
            if (fault_kind == 1 && fault_idx == fetch_idx) mem_cnt = 0;
            else mem_cnt = (mem_fix > 0) ? mem_fix : $urandom_range(lat_max, 1);
            fetch_idx++;
         end
         if (bus.run) begin
            if (fault_kind == 2 && fault_idx == exec_idx) exe_cnt = 0;
            else exe_cnt = (done_fix > 0) ? done_fix : $urandom_range(lat_max, 1);
            exec_idx++;
            if (stray_en) begin
               bus.done   = 1'b1;
               stray_pend = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.run) issued.push_back(bus.d_instr);
         if (bus.mem_rd_en) fetched.push_back(int'(bus.mem_addr));
         if (bus.run && bus.mem_rd_en) viol++;
      end
   end

   // Reference: walk the program from START, stopping at HALT or at the injected fault.
   function automatic void modelRun();
      int a;
      exp_issued.delete();
      exp_fetch.delete();
      a       = START;
      exp_cnt = 0;
      exp_err = 0;
      for (int i = 0; i <= DEPTH; i++) begin
         exp_fetch.push_back(a);
         if (fault_kind == 1 && fault_idx == i) begin
            exp_err = 1;
            break;
         end
         if (mem[a] == HALTW) break;
         exp_issued.push_back(mem[a]);
         if (fault_kind == 2 && fault_idx == i) begin
            exp_err = 1;
            break;
         end
         exp_cnt++;
         a = (a + 1) % DEPTH;
      end
      exp_pc = a;
   endfunction

   function automatic logic [15:0] plainWord();
      logic [15:0] w;
      w = 16'($urandom);
      if (w == HALTW) w = 16'h0000;
      return w;
   endfunction

   task automatic applyStimulus(input string name, output int cycles);
      modelRun();
      issued.delete();
      fetched.delete();
      viol      = 0;
      fetch_idx = 0;
      exec_idx  = 0;
      @(negedge clk);
      start_req = 1'b1;
      @(negedge clk);
      start_req = 1'b0;
      checkOutput({name, "_rd_en_after_start"}, 32'(bus.mem_rd_en), 32'd1);
      checkOutput({name, "_addr_after_start"}, 32'(bus.mem_addr), 32'(START));
      checkOutput({name, "_count_cleared"}, 32'(instr_count), 32'd0);
      checkOutput({name, "_error_cleared"}, 32'(error), 32'd0);
      cycles = 0;
      while (!halted && cycles < 1000) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput({name, "_reached_halt"}, 32'(halted), 32'd1);
      checkOutput({name, "_issue_count"}, 32'(issued.size()), 32'(exp_issued.size()));
      for (int i = 0; i < issued.size() && i < exp_issued.size(); i++)
         checkOutput($sformatf("%s_issued%0d", name, i), 32'(issued[i]), 32'(exp_issued[i]));
      checkOutput({name, "_fetch_count"}, 32'(fetched.size()), 32'(exp_fetch.size()));
      for (int i = 0; i < fetched.size() && i < exp_fetch.size(); i++)
         checkOutput($sformatf("%s_fetch%0d", name, i), 32'(fetched[i]), 32'(exp_fetch[i]));
      if (exp_issued.size() > 0) exp_d = exp_issued[exp_issued.size() - 1];
      checkOutput({name, "_pc"}, 32'(pc), 32'(exp_pc));
      checkOutput({name, "_instr_count"}, 32'(instr_count), 32'(exp_cnt));
      checkOutput({name, "_error"}, 32'(error), 32'(exp_err));
      checkOutput({name, "_d_instr"}, 32'(bus.d_instr), 32'(exp_d));
      checkOutput({name, "_busy"}, 32'(busy), 32'd0);
      checkOutput({name, "_run_rd_overlap"}, 32'(viol), 32'd0);
   endtask

   task automatic resetMidExec();
      int guard;
      for (int i = 0; i < DEPTH; i++) mem[i] = plainWord();
      fault_kind = 0;
      stray_en   = 1'b0;
      mem_fix    = 1;
      done_fix   = 8;
      @(negedge clk);
      start_req = 1'b1;
      @(negedge clk);
      start_req = 1'b0;
      guard = 0;
      while (!(bus.run && instr_count == 16'd5) && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("midexec_reached", 32'(guard < 500), 32'd1);
      @(negedge clk);
      checkOutput("midexec_pc_before", 32'(pc), 32'((START + 5) % DEPTH));
      #2;
      reset = 1'b1;
      #1;
      checkOutput("midexec_pc", 32'(pc), 32'(START));
      checkOutput("midexec_run", 32'(bus.run), 32'd0);
      checkOutput("midexec_rd_en", 32'(bus.mem_rd_en), 32'd0);
      checkOutput("midexec_d_instr", 32'(bus.d_instr), 32'd0);
      checkOutput("midexec_count", 32'(instr_count), 32'd0);
      checkOutput("midexec_busy", 32'(busy), 32'd0);
      checkOutput("midexec_halted", 32'(halted), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      exp_d = 16'h0000;
   endtask

   initial begin
      int cyc;
      reset       = 1'b1;
      start_req   = 1'b0;
      stray_en    = 1'b0;
      stray_pend  = 1'b0;
      fault_kind  = 0;
      fault_idx   = 0;
      mem_fix     = 0;
      done_fix    = 0;
      lat_max     = 4;
      mem_cnt     = 0;
      exe_cnt     = 0;
      viol        = 0;
      exp_d       = 16'h0000;
      for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0000;
      #12;
      checkOutput("reset_pc", 32'(pc), 32'(START));
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_halted", 32'(halted), 32'd0);
      checkOutput("reset_error", 32'(error), 32'd0);
      checkOutput("reset_count", 32'(instr_count), 32'd0);
      checkOutput("reset_d_instr", 32'(bus.d_instr), 32'd0);
      checkOutput("reset_run", 32'(bus.run), 32'd0);
      checkOutput("reset_rd_en", 32'(bus.mem_rd_en), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      $display("[TB] basic program with pc wrap");
      for (int i = 0; i < DEPTH; i++) mem[i] = plainWord();
      mem[6] = 16'h1234;
      mem[7] = 16'h0042;
      mem[0] = HALTW;
      mem_fix  = 1;
      done_fix = 2;
      applyStimulus("basic", cyc);

      $display("[TB] memory timeout");
      fault_kind = 1;
      fault_idx  = 0;
      applyStimulus("memto", cyc);
      checkOutput("memto_within_12", 32'(cyc <= 12), 32'd1);

      $display("[TB] stray done and rvalid");
      fault_kind = 0;
      mem[6] = 16'hA001;
      mem[7] = 16'hA002;
      mem[0] = 16'hA003;
      mem[1] = HALTW;
      stray_en = 1'b1;
      done_fix = 3;
      applyStimulus("stray", cyc);

      $display("[TB] exec timeout");
      stray_en   = 1'b0;
      fault_kind = 2;
      fault_idx  = 1;
      applyStimulus("exto", cyc);

      $display("[TB] reset mid-execute");
      resetMidExec();

      $display("[TB] randomized programs");
      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < DEPTH; i++) mem[i] = plainWord();
         mem[$urandom_range(DEPTH - 1, 0)] = HALTW;
         if ($urandom_range(3, 0) == 0) mem[$urandom_range(DEPTH - 1, 0)] = HALTW;
         mem_fix    = 0;
         done_fix   = 0;
         lat_max    = ($urandom_range(3, 0) == 0) ? TO : $urandom_range(4, 1);
         fault_kind = ($urandom_range(3, 0) == 0) ? $urandom_range(2, 1) : 0;
         fault_idx  = $urandom_range(DEPTH - 1, 0);
         stray_en   = $urandom_range(1, 0) == 1;
         applyStimulus($sformatf("rnd%0d", r), cyc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: observed no finish, expected finish before limit");
      $fatal(1, "[TB] simulation time limit");
   end

endmodule
